// File: rtl/out_display_ctrl.sv
// Output-port display controller: 16-bit binary -> 5 BCD digits (double-dabble) -> active-low 7-seg.
// Optional build macro OUT_DISP_LEADING_BLANK_EN blanks leading zero digits hex1..hex4.
module out_display_ctrl #(
    parameter int DIGITS = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4
);

    localparam int DATA_W = 16;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int SR_W   = BCD_W + DATA_W;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          cnt;
    logic                pending;
    logic                pending_next;
    logic [DATA_W-1:0]   pend_val;
    logic                start;
    logic [DATA_W-1:0]   start_val;
    logic [SR_W-1:0]     sr_p0;
    logic [BCD_W-1:0]    acc_p0;
    logic [4:0]          lead_zero;
    logic [6:0]          seg_p0 [5];

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // One double-dabble step: correct every digit, then shift the whole register left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] r);
        logic [SR_W-1:0] adj;
        adj = r;
        for (int i = 0; i < DIGITS; i++) begin
            adj[DATA_W + 4*i +: 4] = add3(r[DATA_W + 4*i +: 4]);
        end
        return {adj[SR_W-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        state_next   = state;
        pending_next = pending;
        start        = 1'b0;
        start_val    = value;
        case (state)
            IDLE: begin
                if (load) begin
                    start      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (load) begin
                    pending_next = 1'b1;
                end
                if (cnt == 4'd15) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                // A load in the LATCH cycle beats the queued value, which is then dropped.
                if (load) begin
                    start        = 1'b1;
                    pending_next = 1'b0;
                    state_next   = SHIFT;
                end else if (pending) begin
                    start        = 1'b1;
                    start_val    = pend_val;
                    pending_next = 1'b0;
                    state_next   = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pending <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= 4'd0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            busy    <= (state_next != IDLE) || pending_next;
            done    <= (state == LATCH);
            if (start) begin
                cnt <= 4'd0;
            end else if (state == SHIFT) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Stage p0: conversion register and queued value (data only, no reset).
    always_ff @(posedge clock) begin
        if (start) begin
            sr_p0 <= {{BCD_W{1'b0}}, start_val};
        end else if (state == SHIFT) begin
            sr_p0 <= dabble_step(sr_p0);
        end
        if (state == SHIFT && load) begin
            pend_val <= value;
        end
    end

    assign acc_p0 = sr_p0[SR_W-1:DATA_W];

    always_comb begin
        lead_zero[4] = (acc_p0[19:16] == 4'd0);
        for (int i = 3; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (acc_p0[4*i +: 4] == 4'd0);
        end
        for (int i = 0; i < 5; i++) begin
            seg_p0[i] = seg_encode(acc_p0[4*i +: 4]);
`ifdef OUT_DISP_LEADING_BLANK_EN
            if (i > 0 && lead_zero[i]) begin
                seg_p0[i] = SEG_BLANK;
            end
`endif
        end
    end

    // Stage p1: registered display outputs, updated only in LATCH.
    always_ff @(posedge clock) begin
        if (reset) begin
            bcd  <= '0;
            hex0 <= SEG_ZERO;
`ifdef OUT_DISP_LEADING_BLANK_EN
            hex1 <= SEG_BLANK;
            hex2 <= SEG_BLANK;
            hex3 <= SEG_BLANK;
            hex4 <= SEG_BLANK;
`else
            hex1 <= SEG_ZERO;
            hex2 <= SEG_ZERO;
            hex3 <= SEG_ZERO;
            hex4 <= SEG_ZERO;
`endif
        end else if (state == LATCH) begin
            bcd  <= acc_p0;
            hex0 <= seg_p0[0];
            hex1 <= seg_p0[1];
            hex2 <= seg_p0[2];
            hex3 <= seg_p0[3];
            hex4 <= seg_p0[4];
        end
    end

endmodule

// File: tb/tb_out_display_ctrl.sv
// Self-checking bench for out_display_ctrl using a decimal-arithmetic reference model.
module tb_out_display_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] value = 16'd0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4;

    int total = 0;
    int bad   = 0;

    out_display_ctrl #(.DIGITS(5)) dut (
        .clock(clock), .reset(reset), .load(load), .value(value),
        .busy(busy), .done(done), .bcd(bcd),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r = '0;
        for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] ref_hex(input int v, input int i);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
`ifdef OUT_DISP_LEADING_BLANK_EN
        if (i > 0 && v < pow10(i)) return 7'b1111111;
`endif
        return tbl[(v / pow10(i)) % 10];
    endfunction

    function automatic logic [6:0] hex_obs(input int i);
        case (i)
            0: return hex0;
            1: return hex1;
            2: return hex2;
            3: return hex3;
            default: return hex4;
        endcase
    endfunction

    task automatic check_display(input string tag, input int v);
        check({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(v)));
        for (int i = 0; i < 5; i++) check($sformatf("%s_hex%0d", tag, i), 32'(hex_obs(i)), 32'(ref_hex(v, i)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_bcd"}, 32'(bcd), 32'd0);
        check({tag, "_hex0"}, 32'(hex0), 32'h40);
        for (int i = 1; i < 5; i++) begin
`ifdef OUT_DISP_LEADING_BLANK_EN
            check($sformatf("%s_hex%0d", tag, i), 32'(hex_obs(i)), 32'h7F);
`else
            check($sformatf("%s_hex%0d", tag, i), 32'(hex_obs(i)), 32'h40);
`endif
        end
    endtask

    // Isolated conversion: load at E0, expect done exactly 17 edges later.
    task automatic run_one(input logic [15:0] v, input string tag);
        int n = 0;
        load = 1'b1; value = v;
        step();
        load = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        do begin
            step();
            n++;
        end while (!done && n < 40);
        check({tag, "_latency"}, 32'(n), 32'd17);
        check_display(tag, int'(v));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        step();
        check({tag, "_done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Reset with load held: nothing may start.
        reset = 1'b1; load = 1'b1; value = 16'd5;
        repeat (3) step();
        check_reset_outputs("rst");
        reset = 1'b0; load = 1'b0;
        step();
        check("rst_no_start_busy", 32'(busy), 32'd0);
        check("rst_no_start_done", 32'(done), 32'd0);

        run_one(16'd12345, "v12345");
        run_one(16'd65535, "v65535");
        run_one(16'd0, "v0");
        run_one(16'd7, "v7");
        run_one(16'd1000, "v1000");

        // Queueing: 42 at E0, 7 at E3, 9 at E10 -> 42 then 9.
        load = 1'b1; value = 16'd42;
        step();
        for (int k = 1; k <= 34; k++) begin
            load  = (k == 3) || (k == 10);
            value = (k == 3) ? 16'd7 : 16'd9;
            step();
            load = 1'b0;
            check($sformatf("q_done_e%0d", k), 32'(done), 32'((k == 17) || (k == 34)));
            check($sformatf("q_busy_e%0d", k), 32'(busy), 32'(k < 34));
            if (k == 17) check_display("q_first", 42);
            if (k == 34) check_display("q_second", 9);
        end

        // Reset in the middle of a conversion, with a load during reset.
        load = 1'b1; value = 16'd500;
        step();
        load = 1'b0;
        repeat (7) step();
        reset = 1'b1; load = 1'b1; value = 16'd3;
        step();
        reset = 1'b0; load = 1'b0;
        check_reset_outputs("midrst");
        begin
            int seen = 0;
            for (int k = 0; k < 25; k++) begin
                step();
                if (done) seen++;
            end
            check("midrst_no_done", 32'(seen), 32'd0);
        end
        run_one(16'd3, "after_rst");

        // Random isolated conversions.
        for (int r = 0; r < 8; r++) begin
            run_one(16'($urandom_range(0, 65535)), $sformatf("rnd%0d", r));
        end

        // Random chained conversions: newest queued value wins, a LATCH-cycle load wins over it.
        for (int r = 0; r < 4; r++) begin
            int first, last_val, nq;
            bit any;
            first = int'($urandom_range(0, 65535));
            any = 1'b0; last_val = 0;
            load = 1'b1; value = 16'(first);
            step();
            for (int k = 1; k <= 34; k++) begin
                bit do_load;
                int v;
                v = int'($urandom_range(0, 65535));
                do_load = (k <= 17) && (($urandom_range(0, 3) == 0) || (k == 17 && !any && r[0]));
                load = do_load; value = 16'(v);
                if (do_load) begin
                    any = 1'b1; last_val = v;
                end
                step();
                load = 1'b0;
                if (k == 17) check_display($sformatf("ch%0d_a", r), first);
                if (k == 34) begin
                    check($sformatf("ch%0d_done2", r), 32'(done), 32'(any));
                    if (any) check_display($sformatf("ch%0d_b", r), last_val);
                end
            end
            nq = 0;
            while (busy && nq < 40) begin
                step();
                nq++;
            end
            check($sformatf("ch%0d_idle", r), 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
